keypad_scanner: RTL

Scans a physical 4x4 hex keypad and produces the debounced 16-bit `keypad_matrix` consumed by `cpu`, replacing the constant-zero tie-off in the system top. It drives one column low at a time, samples the pulled-up rows and assembles a full frame of 16 keys. A frame is published only after it has been stable for a programmable number of consecutive frames. Bits are remapped from physical position to CHIP-8 key value, and the block flags newly pressed keys for the Fx0A wait-for-key instruction.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_scanner_sync2.sv | 23 ++
 rtl/keypad_scanner.sv | 126 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, scan states and key remap for the keypad scanner
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SAMPLE = 2'd1,
    COMMIT = 2'd2
  } scan_state_e;

  // Nibble p holds the CHIP-8 key at physical index p = col*4 + row.
  localparam logic [63:0] KEY_MAP = 64'hFEDC_B963_0852_A741;

  function automatic logic [15:0] remap(input logic [15:0] frame);
    logic [15:0] m;
    m = '0;
    for (int p = 0; p < 16; p++) begin
      m[KEY_MAP[p*4 +: 4]] = frame[p];
    end
    return m;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// rtl/keypad_scanner_sync2.sv - two-flop synchronizer, resets to all-ones (idle pulled-up rows)
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with frame debounce and new-key event
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [15:0]         keypad_matrix,
  output logic                key_event,
  output logic [3:0]          key_code
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 2);
  localparam logic [3:0]      DEB_MAX  = 4'(DEBOUNCE);

  logic [NUM_ROWS-1:0]          rows_sync;
  scan_state_e                  state, state_nxt;
  logic [1:0]                   col, col_nxt;
  logic [DIV_W-1:0]             div, div_nxt;
  logic [NUM_ROWS*NUM_COLS-1:0] frame, frame_nxt;
  logic [15:0]                  candidate, cand_nxt;
  logic [3:0]                   count, count_nxt;
  logic [15:0]                  matrix_nxt;
  logic                         event_nxt;
  logic [3:0]                   code_nxt;
  logic [15:0]                  mapped;
  logic [15:0]                  new_keys;

  sync2 #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (rows_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= SETTLE;
      col           <= '0;
      div           <= '0;
      frame         <= '0;
      candidate     <= '0;
      count         <= '0;
      keypad_matrix <= '0;
      key_event     <= 1'b0;
      key_code      <= '0;
      col_n         <= 4'b1110;
    end else begin
      state         <= state_nxt;
      col           <= col_nxt;
      div           <= div_nxt;
      frame         <= frame_nxt;
      candidate     <= cand_nxt;
      count         <= count_nxt;
      keypad_matrix <= matrix_nxt;
      key_event     <= event_nxt;
      key_code      <= code_nxt;
      col_n         <= ~(NUM_COLS'(1) << col_nxt);
    end
  end

  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    div_nxt    = div;
    frame_nxt  = frame;
    cand_nxt   = candidate;
    count_nxt  = count;
    matrix_nxt = keypad_matrix;
    event_nxt  = 1'b0;
    code_nxt   = key_code;
    mapped     = remap(frame);
    new_keys   = '0;

    case (state)
      SETTLE: begin
        if (div == DIV_LAST) begin
          div_nxt   = '0;
          state_nxt = SAMPLE;
        end else begin
          div_nxt = div + 1'b1;
        end
      end

      SAMPLE: begin
        frame_nxt[{col, 2'b00} +: NUM_ROWS] = ~rows_sync;
        if (col == 2'd3) begin
          state_nxt = COMMIT;
        end else begin
          col_nxt   = col + 1'b1;
          state_nxt = SETTLE;
        end
      end

      COMMIT: begin
        if (mapped != candidate) begin
          cand_nxt  = mapped;
          count_nxt = 4'd1;
        end else if (count < DEB_MAX) begin
          count_nxt = count + 4'd1;
        end

        if (count_nxt == DEB_MAX && cand_nxt != keypad_matrix) begin
          matrix_nxt = cand_nxt;
          new_keys   = cand_nxt & ~keypad_matrix;
          event_nxt  = |new_keys;
          // Descending scan so the lowest pressed index is the last write.
          for (int i = 15; i >= 0; i--) begin
            if (new_keys[i]) code_nxt = 4'(i);
          end
        end

        col_nxt   = '0;
        state_nxt = SETTLE;
      end

      default: state_nxt = SETTLE;
    endcase
  end

endmodule
